// File: rtl/uart_alu_pkg.sv
// Shared definitions for the ALU-result-to-UART byte path.
package uart_alu_pkg;

  localparam int unsigned byte_width_lp = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } serializer_state_e;

endpackage

// File: rtl/word_serializer_if.sv
// Word-in / byte-out ready/valid bundle for word_serializer.
interface word_serializer_if #(
  parameter int unsigned width_p = 32
);

  logic [width_p-1:0] data_i;
  logic               valid_i;
  logic               ready_o;
  logic               valid_o;
  logic [7:0]         data_o;
  logic               ready_i;
  logic               busy_o;

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, valid_o, data_o, busy_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, valid_o, data_o, busy_o
  );

endinterface

// File: rtl/word_serializer.sv
// Holds one width_p-bit word and streams it out one byte per handshake,
// accepting the next word on the last-byte cycle so words flow without bubbles.
module word_serializer
  import uart_alu_pkg::*;
#(
  parameter int unsigned width_p     = 32,
  parameter bit          msb_first_p = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  word_serializer_if.slave  io
);

  localparam int unsigned bytes_lp  = width_p / byte_width_lp;
  localparam int unsigned cnt_w_lp  = (bytes_lp > 1) ? $clog2(bytes_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(bytes_lp - 1);

  if ((width_p % byte_width_lp) != 0 || width_p < byte_width_lp) begin : g_bad_width
    $error("word_serializer: width_p must be a multiple of 8 and at least 8");
  end

  serializer_state_e   state_q, state_d;
  logic [width_p-1:0]  shift_q, shift_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                last_s;
  logic                ready_s;

  // Next-state, shift and count; ready is combinational from ready_i on the last byte.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    last_s  = (cnt_q == last_cnt_lp);
    ready_s = (state_q == IDLE) || ((state_q == SEND) && last_s && io.ready_i);

    case (state_q)
      IDLE: begin
        if (io.valid_i) begin
          shift_d = io.data_i;
          cnt_d   = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (io.ready_i) begin
          if (!last_s) begin
            if (msb_first_p) begin
              shift_d = shift_q << byte_width_lp;
            end else begin
              shift_d = shift_q >> byte_width_lp;
            end
            cnt_d = cnt_q + cnt_w_lp'(1);
          end else if (io.valid_i) begin
            shift_d = io.data_i;
            cnt_d   = '0;
            state_d = SEND;
          end else begin
            // Clearing on return to IDLE keeps data_o at 00 while nothing is held.
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        shift_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, shift register and byte counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.ready_o = ready_s;
  assign io.valid_o = (state_q == SEND);
  assign io.busy_o  = (state_q == SEND);
  assign io.data_o  = msb_first_p ? shift_q[width_p-1 -: byte_width_lp]
                                  : shift_q[byte_width_lp-1:0];

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: LSB-first 32-bit, MSB-first 32-bit and 8-bit instances.
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  word_serializer_if #(.width_p(32)) a();
  word_serializer_if #(.width_p(32)) b();
  word_serializer_if #(.width_p(8))  c();

  word_serializer #(.width_p(32), .msb_first_p(1'b0)) dut_lsb (.clk_i(clk), .reset_ni(rst_n), .io(a.slave));
  word_serializer #(.width_p(32), .msb_first_p(1'b1)) dut_msb (.clk_i(clk), .reset_ni(rst_n), .io(b.slave));
  word_serializer #(.width_p(8),  .msb_first_p(1'b0)) dut_w8  (.clk_i(clk), .reset_ni(rst_n), .io(c.slave));

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    qa.push_back(b0); qa.push_back(b1); qa.push_back(b2); qa.push_back(b3);
  endtask

  // Monitors: pop the expected byte on every output handshake.
  always @(negedge clk) begin
    check("busy_eq_valid_a", {31'd0, a.busy_o}, {31'd0, a.valid_o});
    if (rst_n && a.valid_o && a.ready_i) begin
      if (qa.size() == 0) check("unexpected_byte_a", {24'd0, a.data_o}, 32'hFFFF_FFFF);
      else check("byte_a", {24'd0, a.data_o}, {24'd0, qa.pop_front()});
    end
  end

  always @(negedge clk) begin
    check("busy_eq_valid_b", {31'd0, b.busy_o}, {31'd0, b.valid_o});
    if (rst_n && b.valid_o && b.ready_i) begin
      if (qb.size() == 0) check("unexpected_byte_b", {24'd0, b.data_o}, 32'hFFFF_FFFF);
      else check("byte_b", {24'd0, b.data_o}, {24'd0, qb.pop_front()});
    end
  end

  always @(negedge clk) begin
    check("busy_eq_valid_c", {31'd0, c.busy_o}, {31'd0, c.valid_o});
    if (rst_n && c.valid_o && c.ready_i) begin
      if (qc.size() == 0) check("unexpected_byte_c", {24'd0, c.data_o}, 32'hFFFF_FFFF);
      else check("byte_c", {24'd0, c.data_o}, {24'd0, qc.pop_front()});
    end
  end

  initial begin
    logic [9:0] bp_pat;
    logic [7:0] prev_data;
    logic       prev_valid;
    bp_pat = 10'b1100101001; // bit k is ready_i in backpressure cycle k
    rst_n = 1'b0;
    a.data_i = '0; a.valid_i = 1'b0; a.ready_i = 1'b0;
    b.data_i = '0; b.valid_i = 1'b0; b.ready_i = 1'b0;
    c.data_i = '0; c.valid_i = 1'b0; c.ready_i = 1'b0;

    // Reset state
    #1;
    check("rst_valid", {31'd0, a.valid_o}, 32'd0);
    check("rst_data",  {24'd0, a.data_o},  32'h00);
    check("rst_ready", {31'd0, a.ready_o}, 32'd1);
    check("rst_busy",  {31'd0, a.busy_o},  32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset in the middle of a word: outputs drop before any clock edge
    @(posedge clk); #1 a.data_i = 32'hCAFE_F00D; a.valid_i = 1'b1; a.ready_i = 1'b0;
    @(posedge clk); #1 a.valid_i = 1'b0;
    @(negedge clk);
    check("midword_valid", {31'd0, a.valid_o}, 32'd1);
    check("midword_data",  {24'd0, a.data_o},  32'h0D);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, a.valid_o}, 32'd0);
    check("async_rst_data",  {24'd0, a.data_o},  32'h00);
    check("async_rst_ready", {31'd0, a.ready_o}, 32'd1);
    check("async_rst_busy",  {31'd0, a.busy_o},  32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 a.ready_i = 1'b1;
    @(negedge clk);
    check("no_resume_valid", {31'd0, a.valid_o}, 32'd0);

    // Single word, LSB first, ready_i high
    push_a(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    @(posedge clk); #1 a.data_i = 32'hDDCC_BBAA; a.valid_i = 1'b1;
    @(negedge clk);
    check("single_accept_ready", {31'd0, a.ready_o}, 32'd1);
    @(posedge clk); #1 a.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("single_valid", {31'd0, a.valid_o}, 32'd1);
      check("single_ready", {31'd0, a.ready_o}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("single_idle", {31'd0, a.valid_o}, 32'd0);

    // Back-to-back words with valid_i held: no bubble between 44 and 55
    push_a(8'h11, 8'h22, 8'h33, 8'h44);
    push_a(8'h55, 8'h66, 8'h77, 8'h88);
    @(posedge clk); #1 a.data_i = 32'h4433_2211; a.valid_i = 1'b1;
    @(negedge clk);
    check("b2b_first_accept", {31'd0, a.ready_o}, 32'd1);
    @(posedge clk); #1 a.data_i = 32'h8877_6655;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_w0_valid", {31'd0, a.valid_o}, 32'd1);
      check("b2b_w0_ready", {31'd0, a.ready_o}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1 a.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_w1_valid", {31'd0, a.valid_o}, 32'd1);
      check("b2b_w1_ready", {31'd0, a.ready_o}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("b2b_idle", {31'd0, a.valid_o}, 32'd0);

    // Backpressure: output must hold while ready_i is low
    push_a(8'h01, 8'h02, 8'h03, 8'h04);
    @(posedge clk); #1 a.data_i = 32'h0403_0201; a.valid_i = 1'b1; a.ready_i = 1'b0;
    @(posedge clk); #1 a.valid_i = 1'b0;
    prev_data = 8'h00; prev_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a.ready_i = bp_pat[k];
      @(negedge clk);
      if (k > 0 && !bp_pat[k-1]) begin
        check("bp_hold_data",  {24'd0, a.data_o},  {24'd0, prev_data});
        check("bp_hold_valid", {31'd0, a.valid_o}, {31'd0, prev_valid});
      end
      prev_data  = a.data_o;
      prev_valid = a.valid_o;
      @(posedge clk); #1;
    end
    a.ready_i = 1'b1;
    @(negedge clk);
    check("bp_drained", qa.size(), 32'd0);

    // MSB-first instance
    qb.push_back(8'h0A); qb.push_back(8'h0B); qb.push_back(8'h0C); qb.push_back(8'h0D);
    @(posedge clk); #1 b.data_i = 32'h0A0B_0C0D; b.valid_i = 1'b1; b.ready_i = 1'b1;
    @(posedge clk); #1 b.valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("msb_valid", {31'd0, b.valid_o}, 32'd1);
    end
    @(negedge clk);
    check("msb_drained", qb.size(), 32'd0);

    // 8-bit instance: one word per cycle
    qc.push_back(8'h5A); qc.push_back(8'hA5);
    @(posedge clk); #1 c.data_i = 8'h5A; c.valid_i = 1'b1; c.ready_i = 1'b1;
    @(negedge clk);
    check("w8_accept0", {31'd0, c.ready_o}, 32'd1);
    @(posedge clk); #1 c.data_i = 8'hA5;
    @(negedge clk);
    check("w8_valid0", {31'd0, c.valid_o}, 32'd1);
    check("w8_accept1", {31'd0, c.ready_o}, 32'd1);
    @(posedge clk); #1 c.valid_i = 1'b0;
    @(negedge clk);
    check("w8_valid1", {31'd0, c.valid_o}, 32'd1);
    @(negedge clk);
    check("w8_idle", {31'd0, c.valid_o}, 32'd0);
    check("w8_drained", qc.size(), 32'd0);

    // Random valid/ready traffic on the LSB-first instance
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      a.valid_i = 1'($urandom_range(0, 1));
      a.data_i  = $urandom;
      a.ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (a.valid_i && a.ready_o) begin
        for (int j = 0; j < 4; j++) qa.push_back(a.data_i[8*j +: 8]);
      end
    end
    @(posedge clk); #1 a.valid_i = 1'b0; a.ready_i = 1'b1;
    repeat (12) @(negedge clk);
    check("random_drained", qa.size(), 32'd0);
    check("random_idle", {31'd0, a.valid_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
